// File: rtl/raisin64_sched_pkg.sv
// Shared definitions for the issue scheduler: FSM states, default sizes,
// and the execution-unit indices that decode places in its unit field.
package raisin64_sched_pkg;

    localparam int DEF_NREG  = 64;
    localparam int DEF_NUNIT = 8;
    localparam int DEF_CNTW  = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_e;

    localparam logic [2:0] UNIT_ALU0 = 3'd0;
    localparam logic [2:0] UNIT_ALU1 = 3'd1;
    localparam logic [2:0] UNIT_MUL  = 3'd2;
    localparam logic [2:0] UNIT_DIV  = 3'd3;
    localparam logic [2:0] UNIT_LSU  = 3'd4;
    localparam logic [2:0] UNIT_BRU  = 3'd5;
    localparam logic [2:0] UNIT_FPU  = 3'd6;
    localparam logic [2:0] UNIT_SYS  = 3'd7;

endpackage

// File: rtl/sc_busy_array.sv
// Per-register busy flops with two set and two clear ports; a set beats a
// clear of the same register, and eb_o shows busy with writebacks bypassed.
module sc_busy_array
    import raisin64_sched_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set0_v_i,
    input  logic [RW-1:0]   set0_rn_i,
    input  logic            set1_v_i,
    input  logic [RW-1:0]   set1_rn_i,
    input  logic            clr0_v_i,
    input  logic [RW-1:0]   clr0_rn_i,
    input  logic            clr1_v_i,
    input  logic [RW-1:0]   clr1_rn_i,
    output logic [NREG-1:0] busy_o,
    output logic [NREG-1:0] eb_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            logic set_hit;
            logic clr_hit;
            // Register 0 is hardwired idle: it can never be set or reported busy.
            if (gi == 0) begin : g_zero
                assign set_hit = 1'b0;
                assign clr_hit = 1'b0;
            end else begin : g_reg
                assign set_hit = (set0_v_i && (set0_rn_i == RW'(gi)))
                              || (set1_v_i && (set1_rn_i == RW'(gi)));
                assign clr_hit = (clr0_v_i && (clr0_rn_i == RW'(gi)))
                              || (clr1_v_i && (clr1_rn_i == RW'(gi)));
            end
            assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
            assign eb_o[gi]   = busy_q[gi] & ~clr_hit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/de_scoreboard.sv
// Issue scheduler: checks the decoded instruction for register and unit
// hazards, issues it when safe, and drives the decode advance handshake.
module de_scoreboard
    import raisin64_sched_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int NUNIT = DEF_NUNIT,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dec_valid,
    input  logic [$clog2(NUNIT)-1:0]   unit,
    input  logic [$clog2(NREG)-1:0]    r1_rn,
    input  logic [$clog2(NREG)-1:0]    r2_rn,
    input  logic [$clog2(NREG)-1:0]    rd_rn,
    input  logic [$clog2(NREG)-1:0]    rd2_rn,
    input  logic                       rd_we,
    input  logic                       rd2_we,
    input  logic [NUNIT-1:0]           unit_busy,
    input  logic                       wb0_valid,
    input  logic                       wb1_valid,
    input  logic [$clog2(NREG)-1:0]    wb0_rn,
    input  logic [$clog2(NREG)-1:0]    wb1_rn,
    input  logic                       flush,
    output logic                       issue,
    output logic                       allow_advance,
    output logic [NREG-1:0]            busy_vec,
    output logic [CNTW-1:0]            stall_cnt
);

    sched_state_e    state_q;
    sched_state_e    state_d;
    logic [CNTW-1:0] stall_cnt_q;
    logic [NREG-1:0] eb;
    logic            hazard;

    sc_busy_array #(
        .NREG (NREG)
    ) u_busy (
        .clk       (clk),
        .rst_n     (rst_n),
        .set0_v_i  (issue & rd_we),
        .set0_rn_i (rd_rn),
        .set1_v_i  (issue & rd2_we),
        .set1_rn_i (rd2_rn),
        .clr0_v_i  (wb0_valid),
        .clr0_rn_i (wb0_rn),
        .clr1_v_i  (wb1_valid),
        .clr1_rn_i (wb1_rn),
        .busy_o    (busy_vec),
        .eb_o      (eb)
    );

    always_comb begin
        hazard = eb[r1_rn] | eb[r2_rn]
               | (rd_we & eb[rd_rn]) | (rd2_we & eb[rd2_rn])
               | unit_busy[unit];
    end

    // Outputs are forced low while reset is held so nothing leaves the slot.
    always_comb begin
        issue         = 1'b0;
        allow_advance = 1'b0;
        if (rst_n) begin
            issue         = (state_q != ST_FLUSH) & dec_valid & ~hazard & ~flush;
            allow_advance = issue | ~dec_valid | (state_q == ST_FLUSH);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (dec_valid && hazard) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (issue) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: state_d = flush ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_STALL) && (stall_cnt_q != {CNTW{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_de_scoreboard.sv
// Directed test-plan scenarios followed by random traffic, each cycle
// compared against a register-level reference model of the scheduler.
module tb_de_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [2:0]  unit;
    logic [5:0]  r1_rn, r2_rn, rd_rn, rd2_rn;
    logic        rd_we, rd2_we;
    logic [7:0]  unit_busy;
    logic        wb0_valid, wb1_valid;
    logic [5:0]  wb0_rn, wb1_rn;
    logic        flush;
    logic        issue;
    logic        allow_advance;
    logic [63:0] busy_vec;
    logic [15:0] stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model: mode 0 = running, 1 = stalled, 2 = flush bubble.
    bit [63:0]   m_busy = '0;
    int          m_mode = 0;
    int unsigned m_cnt  = 0;
    bit [63:0]   n_busy;
    int          n_mode;
    int unsigned n_cnt;

    de_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_valid     (dec_valid),
        .unit          (unit),
        .r1_rn         (r1_rn),
        .r2_rn         (r2_rn),
        .rd_rn         (rd_rn),
        .rd2_rn        (rd2_rn),
        .rd_we         (rd_we),
        .rd2_we        (rd2_we),
        .unit_busy     (unit_busy),
        .wb0_valid     (wb0_valid),
        .wb1_valid     (wb1_valid),
        .wb0_rn        (wb0_rn),
        .wb1_rn        (wb1_rn),
        .flush         (flush),
        .issue         (issue),
        .allow_advance (allow_advance),
        .busy_vec      (busy_vec),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pending(input int r);
        if (r == 0 || !m_busy[r]) return 1'b0;
        if (wb0_valid && int'(wb0_rn) == r) return 1'b0;
        if (wb1_valid && int'(wb1_rn) == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        dec_valid = 0; unit = 0; r1_rn = 0; r2_rn = 0; rd_rn = 0; rd2_rn = 0;
        rd_we = 0; rd2_we = 0; unit_busy = 0; wb0_valid = 0; wb1_valid = 0;
        wb0_rn = 0; wb1_rn = 0; flush = 0;
    endtask

    // Called right after a falling edge with inputs applied.
    task automatic settle_check();
        bit hz, e_issue, e_adv;
        #1;
        hz = pending(int'(r1_rn)) || pending(int'(r2_rn))
          || (rd_we && pending(int'(rd_rn))) || (rd2_we && pending(int'(rd2_rn)))
          || unit_busy[unit];
        e_issue = rst_n && (m_mode != 2) && dec_valid && !hz && !flush;
        e_adv   = rst_n && (e_issue || !dec_valid || m_mode == 2);
        check_eq("issue", {63'd0, issue}, {63'd0, e_issue});
        check_eq("allow_advance", {63'd0, allow_advance}, {63'd0, e_adv});
        check_eq("busy_vec", busy_vec, m_busy);
        check_eq("stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
        $display("[TB] cyc=%0d rst_n=%b dv=%b fl=%b issue=%b adv=%b busy=%h cnt=%0d",
                 cyc, rst_n, dec_valid, flush, issue, allow_advance, busy_vec, stall_cnt);
        if (!rst_n) begin
            n_busy = '0; n_mode = 0; n_cnt = 0;
        end else begin
            n_cnt = (m_mode == 1 && m_cnt < 32'hFFFF) ? m_cnt + 1 : m_cnt;
            n_busy = m_busy;
            if (wb0_valid) n_busy[wb0_rn] = 1'b0;
            if (wb1_valid) n_busy[wb1_rn] = 1'b0;
            if (e_issue && rd_we  && rd_rn  != 0) n_busy[rd_rn]  = 1'b1;
            if (e_issue && rd2_we && rd2_rn != 0) n_busy[rd2_rn] = 1'b1;
            if (flush)                          n_mode = 2;
            else if (m_mode == 0 && dec_valid && hz) n_mode = 1;
            else if (m_mode == 1 && e_issue)    n_mode = 0;
            else if (m_mode == 2)               n_mode = 0;
            else                                n_mode = m_mode;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        m_busy = n_busy; m_mode = n_mode; m_cnt = n_cnt;
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        step();
        settle_check();
        check_eq("rst_issue", {63'd0, issue}, 64'd0);
        check_eq("rst_adv", {63'd0, allow_advance}, 64'd0);
        advance();
        rst_n = 1;
        check_eq("rst_busy", busy_vec, 64'd0);
        check_eq("rst_cnt", {48'd0, stall_cnt}, 64'd0);

        // Independent instruction issues immediately.
        dec_valid = 1; r1_rn = 1; r2_rn = 2; rd_rn = 3; rd_we = 1;
        settle_check();
        check_eq("ind_issue", {63'd0, issue}, 64'd1);
        check_eq("ind_adv", {63'd0, allow_advance}, 64'd1);
        advance();
        check_eq("ind_busy3", {63'd0, busy_vec[3]}, 64'd1);

        // RAW on r5: writer, then a reader that stalls until writeback.
        r1_rn = 0; r2_rn = 0; rd_rn = 5; rd_we = 1;
        step();
        r1_rn = 5; rd_we = 0;
        settle_check();
        check_eq("raw_stall", {63'd0, issue}, 64'd0);
        advance();
        repeat (3) step();
        check_eq("raw_cnt3", {48'd0, stall_cnt}, 64'd3);
        wb0_valid = 1; wb0_rn = 5;
        settle_check();
        check_eq("raw_wb_issue", {63'd0, issue}, 64'd1);
        advance();
        check_eq("raw_busy5", {63'd0, busy_vec[5]}, 64'd0);
        wb0_valid = 0; r1_rn = 0;

        // Register 0 is never marked busy.
        rd_rn = 0; rd_we = 1;
        step();
        rd_we = 0; r1_rn = 0; r2_rn = 0;
        settle_check();
        check_eq("r0_issue", {63'd0, issue}, 64'd1);
        check_eq("r0_busy", {63'd0, busy_vec[0]}, 64'd0);
        advance();

        // Same-cycle set and writeback clear of r7: set wins.
        rd_rn = 7; rd_we = 1; wb1_valid = 1; wb1_rn = 7;
        step();
        wb1_valid = 0; rd_we = 0;
        check_eq("coll_busy7", {63'd0, busy_vec[7]}, 64'd1);

        // Busy target unit blocks, release issues the same cycle.
        unit = 3'd2; unit_busy = 8'b0000_0100;
        settle_check();
        check_eq("unit_block", {63'd0, issue}, 64'd0);
        advance();
        unit_busy = 0;
        settle_check();
        check_eq("unit_free", {63'd0, issue}, 64'd1);
        advance();
        unit = 0;

        // Flush while stalled on r7.
        r1_rn = 7;
        step();
        flush = 1;
        step();
        flush = 0;
        settle_check();
        check_eq("flush_adv", {63'd0, allow_advance}, 64'd1);
        check_eq("flush_issue", {63'd0, issue}, 64'd0);
        advance();
        check_eq("flush_keep7", {63'd0, busy_vec[7]}, 64'd1);
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        check_eq("post_rst_busy", busy_vec, 64'd0);
        check_eq("post_rst_cnt", {48'd0, stall_cnt}, 64'd0);

        // Random traffic on a small register window to provoke hazards.
        repeat (600) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            dec_valid = ($urandom_range(0, 4) != 0);
            unit      = 3'($urandom_range(0, 7));
            r1_rn     = 6'($urandom_range(0, 7));
            r2_rn     = 6'($urandom_range(0, 7));
            rd_rn     = 6'($urandom_range(0, 7));
            rd2_rn    = 6'($urandom_range(0, 7));
            rd_we     = 1'($urandom_range(0, 1));
            rd2_we    = ($urandom_range(0, 3) == 0);
            for (int u = 0; u < 8; u++) unit_busy[u] = ($urandom_range(0, 9) == 0);
            wb0_valid = ($urandom_range(0, 2) == 0);
            wb1_valid = ($urandom_range(0, 2) == 0);
            wb0_rn    = 6'($urandom_range(0, 7));
            wb1_rn    = 6'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/de_scoreboard.md
# de_scoreboard

Issue scheduler sitting between instruction decode and the execution units. It keeps a per-register busy scoreboard, checks the instruction held in the decode output register for RAW/WAW hazards and target-unit availability, and issues it when safe. It generates the `allow_advance` feedback that lets decode and fetch move forward. It clears busy bits from two writeback ports and counts stall cycles for performance monitoring.

## Interface
Parameters:
- `NREG`, 64: architectural registers; register 0 is never busy.
- `NUNIT`, 8: execution units, indexed by decode `unit`.
- `CNTW`, 16: stall counter width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `dec_valid` in 1: decode output register holds a valid instruction.
- `unit` in 3: target unit of the decoded instruction.
- `r1_rn`, `r2_rn` in 6 each: source registers read by the instruction; 0 means none.
- `rd_rn`, `rd2_rn` in 6 each: destination registers.
- `rd_we`, `rd2_we` in 1 each: the matching destination is written.
- `unit_busy` in NUNIT: unit cannot accept an instruction this cycle.
- `wb0_valid`, `wb1_valid` in 1 each: writeback completes.
- `wb0_rn`, `wb1_rn` in 6 each: registers written back.
- `flush` in 1: redirect; discard the decoded instruction.
- `issue` out 1: instruction dispatched this cycle.
- `allow_advance` out 1: decode slot may be reloaded (to decode).
- `busy_vec` out NREG: current scoreboard, registered.
- `stall_cnt` out CNTW: saturating count of hazard-stall cycles.

## Operation
- Effective busy: `eb[i] = busy[i] & ~(wb0_valid & wb0_rn==i) & ~(wb1_valid & wb1_rn==i)`. Writeback bypasses in the same cycle. `eb[0]` is always 0.
- Hazard when any of the following holds: `eb[r1_rn]`, `eb[r2_rn]`, `rd_we & eb[rd_rn]`, `rd2_we & eb[rd2_rn]`, `unit_busy[unit]`.
- `issue = (state==RUN|state==STALL) & dec_valid & ~hazard & ~flush`.
- `allow_advance = issue | (~dec_valid & state!=FLUSH_HOLD) | state==FLUSH`.
- Busy update on issue: set `busy[rd_rn]` if `rd_we`, and set `busy[rd2_rn]` if `rd2_we`. Register 0 is never set.
- Set and clear of the same register in the same cycle: set wins.
- `rd_rn==rd2_rn` with both write enables: a single bit is set.
- Simultaneous `wb0_rn==wb1_rn`: the bit is cleared once, with no error.
- FSM:
  - RUN: `flush`→FLUSH. `dec_valid & hazard`→STALL. Otherwise stay in RUN.
  - STALL: `flush`→FLUSH. Issue→RUN. Otherwise stay in STALL. `stall_cnt` increments every STALL cycle, saturating at all-ones.
  - FLUSH: lasts exactly 1 cycle. `issue`=0, `allow_advance`=1 so decode refills from the redirected fetch, and `dec_valid` is ignored. Next state is RUN, or FLUSH again if `flush` is still asserted.
  - FLUSH_HOLD is not a state. The term above reads as `1`, so `allow_advance` is simply `issue | ~dec_valid | state==FLUSH`.
- Flush does not clear the scoreboard: in-flight writes still complete through the writeback ports.

## Timing
- Reset (`rst_n` low at an edge): state=RUN, `busy`=0, `busy_vec`=0, `stall_cnt`=0.
- While `rst_n` is low, `issue`=0 and `allow_advance`=0 combinationally.
- Reset mid-stall discards all pending busy bits.
- `issue` and `allow_advance` are combinational from the current-cycle inputs and state, with 0 latency.
- Busy bits set by an issue at edge N are visible in `busy_vec` and hazard checks from cycle N+1.
- Writeback at cycle N unblocks a dependent instruction in cycle N itself, through the bypass.
- Back-to-back dependent instructions (I1 writes r5, I2 reads r5) stall from the cycle after I1 issues until writeback of r5.
- No combinational path from `issue` back into the `unit_busy` or `wb*` inputs is allowed.

## Structure
- Shared package `raisin64_sched_pkg` holds:
  - the state enum (RUN, STALL, FLUSH);
  - `NREG`, `NUNIT`, `CNTW` defaults;
  - the unit index constants used by decode.
- Sub-module `sc_busy_array`: NREG busy flops with 2 set ports, 2 clear ports, set-over-clear priority, and the effective-busy bypass output. It is instantiated once.
- The top level holds the hazard compare, the FSM and the counter.

## Test plan
- Independent stream: `dec_valid`=1, r1=1, r2=2, rd=3 `rd_we`, all units free → `issue`=1 and `allow_advance`=1 in the same cycle; next cycle `busy_vec[3]`=1.
- RAW stall: issue a write to r5, then present an instruction reading r5 → `issue`=0 and state=STALL. `stall_cnt` counts 3 after 3 cycles. `wb0_valid`, `wb0_rn`=5 → issue in that same cycle, and `busy_vec[5]`=0 next cycle.
- Register 0: `rd_rn`=0 `rd_we`=1 issued, then a reader of r0 → `busy_vec[0]` stays 0 and there is no stall.
- Set/clear collision: issue writing r7 while `wb1_rn`=7 is valid → `busy_vec[7]`=1 afterwards.
- Unit busy: `unit`=2 with `unit_busy[2]`=1 → no issue. Deasserting it → issue the same cycle.
- Flush in STALL: `flush`=1 → next cycle FLUSH with `allow_advance`=1 and `issue`=0, then RUN. Busy bits are retained. Reset pulse afterwards → `busy_vec`=0 and `stall_cnt`=0.
